// File: rtl/idma_req_queue.sv
// In-order burst request FIFO with an outstanding-transfer launch gate, aggregate
// idle status, and registered read/write completion events snooped from AXI R/B.
module idma_req_queue #(
  parameter type                   burst_req_t    = logic,
  parameter int unsigned           Depth          = 4,
  parameter int unsigned           MaxOutstanding = 8,
  parameter int unsigned           AxiIdWidth     = 4,
  parameter logic [AxiIdWidth-1:0] AxiId          = AxiIdWidth'(1),
  localparam int unsigned          OutW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  burst_req_t            req_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output burst_req_t            req_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic                  trans_complete_i,
  input  logic                  backend_idle_i,
  output logic                  idle_o,
  output logic [OutW-1:0]       outstanding_o,
  input  logic                  axi_rvalid_i,
  input  logic                  axi_rready_i,
  input  logic                  axi_rlast_i,
  input  logic [AxiIdWidth-1:0] axi_rid_i,
  input  logic                  axi_bvalid_i,
  input  logic                  axi_bready_i,
  input  logic [AxiIdWidth-1:0] axi_bid_i,
  output logic                  r_done_o,
  output logic                  w_done_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  burst_req_t            r_mem [Depth];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_count;
  logic [OutW-1:0]       r_outstanding;
  logic                  r_rd_evt;
  logic                  r_wr_evt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_retire;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_gate_open;

  assign w_fifo_full  = (r_count == CntW'(Depth));
  assign w_fifo_empty = (r_count == '0);
  assign w_gate_open  = (r_outstanding < OutW'(MaxOutstanding));

  // Ready looks at occupancy only, so a full queue never accepts even while popping.
  assign req_ready_o = !w_fifo_full;
  assign req_valid_o = !w_fifo_empty && w_gate_open;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_pop       = req_valid_o && req_ready_i;

  // A completion with nothing in flight is stale (e.g. from before a reset) and is dropped.
  assign w_retire = trans_complete_i && ((r_outstanding != '0) || w_pop);

  assign req_o         = r_mem[r_rptr];
  assign outstanding_o = r_outstanding;
  assign idle_o        = w_fifo_empty && (r_outstanding == '0) && backend_idle_i;
  assign r_done_o      = r_rd_evt;
  assign w_done_o      = r_wr_evt;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else begin
      case ({w_pop, w_retire})
        2'b10:   r_outstanding <= r_outstanding + OutW'(1);
        2'b01:   r_outstanding <= r_outstanding - OutW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_evt <= 1'b0;
      r_wr_evt <= 1'b0;
    end else begin
      r_rd_evt <= axi_rvalid_i && axi_rready_i && axi_rlast_i && (axi_rid_i == AxiId);
      r_wr_evt <= axi_bvalid_i && axi_bready_i && (axi_bid_i == AxiId);
    end
  end

  a_no_stale_complete : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(trans_complete_i && !w_pop && (r_outstanding == '0)));

  a_outstanding_cap : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_outstanding <= OutW'(MaxOutstanding));

endmodule

// File: tb/tb_idma_req_queue.sv
// Scenario bench for idma_req_queue: popped requests are checked in order against a
// scoreboard filled on every accepted push; other outputs are checked inline per task.
module tb_idma_req_queue;

  typedef struct packed {
    logic [7:0]  tag;
    logic [23:0] len;
  } req_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  req_t       req_i = '0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  req_t       req_o;
  logic       req_valid_o;
  logic       req_ready_i = 1'b0;
  logic       trans_complete_i = 1'b0;
  logic       backend_idle_i = 1'b1;
  logic       idle_o;
  logic [1:0] outstanding_o;
  logic       axi_rvalid_i = 1'b0;
  logic       axi_rready_i = 1'b0;
  logic       axi_rlast_i = 1'b0;
  logic [3:0] axi_rid_i = '0;
  logic       axi_bvalid_i = 1'b0;
  logic       axi_bready_i = 1'b0;
  logic [3:0] axi_bid_i = '0;
  logic       r_done_o;
  logic       w_done_o;

  int   n_checks = 0;
  int   n_fail = 0;
  int   pops = 0;
  req_t exp_q[$];
  req_t sb_exp;

  idma_req_queue #(
    .burst_req_t   (req_t),
    .Depth         (4),
    .MaxOutstanding(2),
    .AxiIdWidth    (4),
    .AxiId         (4'd1)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_o           (req_o),
    .req_valid_o     (req_valid_o),
    .req_ready_i     (req_ready_i),
    .trans_complete_i(trans_complete_i),
    .backend_idle_i  (backend_idle_i),
    .idle_o          (idle_o),
    .outstanding_o   (outstanding_o),
    .axi_rvalid_i    (axi_rvalid_i),
    .axi_rready_i    (axi_rready_i),
    .axi_rlast_i     (axi_rlast_i),
    .axi_rid_i       (axi_rid_i),
    .axi_bvalid_i    (axi_bvalid_i),
    .axi_bready_i    (axi_bready_i),
    .axi_bid_i       (axi_bid_i),
    .r_done_o        (r_done_o),
    .w_done_o        (w_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: record accepted pushes, compare each pop against the oldest entry.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      if (req_valid_i && req_ready_o) exp_q.push_back(req_i);
      if (req_valid_o && req_ready_i) begin
        n_checks++;
        pops++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_order: popped tag=%h len=%0d, required nothing queued", req_o.tag, req_o.len);
        end else begin
          sb_exp = exp_q.pop_front();
          if (req_o !== sb_exp) begin
            n_fail++;
            $display("FAIL pop_order: popped tag=%h len=%0d, required tag=%h len=%0d",
                     req_o.tag, req_o.len, sb_exp.tag, sb_exp.len);
          end else begin
            $display("pop tag=%h len=%0d outstanding=%0d", req_o.tag, req_o.len, outstanding_o);
          end
        end
      end
    end
  end

  function automatic req_t mk(input logic [7:0] t, input logic [23:0] l);
    req_t r;
    r.tag = t;
    r.len = l;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Retire completions until the queue and backend are empty; bounded.
  task automatic drain(input string name, input int p0, input int exp_pops);
    int c;
    logic acc;
    for (c = 0; c < 40; c++) begin
      if ((pops - p0) == exp_pops && outstanding_o == 2'd0 && !req_valid_i) break;
      acc = req_valid_i && req_ready_o;
      trans_complete_i = (outstanding_o != 2'd0);
      step();
      if (acc) req_valid_i = 1'b0;
    end
    trans_complete_i = 1'b0;
    n_checks++;
    if (c >= 40) begin n_fail++; $display("FAIL %s_drain_timeout: pops=%0d outstanding=%0d, required pops=%0d outstanding=0", name, pops - p0, outstanding_o, exp_pops); end
    n_checks++;
    if ((pops - p0) != exp_pops) begin n_fail++; $display("FAIL %s_pop_count: got %0d, required %0d", name, pops - p0, exp_pops); end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    backend_idle_i = 1'b1;
    step(); step();
    n_checks++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", req_valid_o); end
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", req_ready_o); end
    n_checks++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, required 1", idle_o); end
    n_checks++; if ({r_done_o, w_done_o} !== 2'b00) begin n_fail++; $display("FAIL reset_events: got %b, required 00", {r_done_o, w_done_o}); end
    backend_idle_i = 1'b0;
    #1;
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_follow: got %b, required 0", idle_o); end
    backend_idle_i = 1'b1;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_t a;
    a = mk(8'hA0, 24'd64);
    req_ready_i = 1'b1;
    req_i = a;
    req_valid_i = 1'b1;
    #1;
    n_checks++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_fallthrough: got %b, required 0", req_valid_o); end
    step();
    req_valid_i = 1'b0;
    n_checks++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid_next: got %b, required 1", req_valid_o); end
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_queued: got %b, required 0", idle_o); end
    step();
    n_checks++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d, required 1", outstanding_o); end
    n_checks++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_after_pop: got %b, required 0", req_valid_o); end
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_inflight: got %b, required 0", idle_o); end
    trans_complete_i = 1'b1;
    step();
    trans_complete_i = 1'b0;
    n_checks++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL single_retire: got %0d, required 0", outstanding_o); end
    n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL single_idle_done: got %b, required 1", idle_o); end
    backend_idle_i = 1'b0;
    #1;
    n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_backend: got %b, required 0", idle_o); end
    backend_idle_i = 1'b1;
  endtask

  task automatic test_fill();
    int p0;
    p0 = pops;
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_i = mk(8'(8'hB0 + i), 24'(16 * (i + 1)));
      req_valid_i = 1'b1;
      n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b, required 1", i, req_ready_o); end
      step();
    end
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b, required 0", req_ready_o); end
    req_i = mk(8'hB4, 24'd80);
    step(); step();
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_held: got %b, required 0", req_ready_o); end
    n_checks++; if (pops != p0) begin n_fail++; $display("FAIL fill_no_pop_stalled: got %0d pops, required 0", pops - p0); end
    req_ready_i = 1'b1;
    drain("fill", p0, 5);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_leftover: got %0d entries, required 0", exp_q.size()); end
  endtask

  task automatic test_outstanding();
    int p0;
    p0 = pops;
    req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_i = mk(8'(8'hC0 + i), 24'(100 + i));
      req_valid_i = 1'b1;
      step();
    end
    req_valid_i = 1'b0;
    req_ready_i = 1'b1;
    step(); step();
    n_checks++; if ((pops - p0) != 2) begin n_fail++; $display("FAIL cap_pops: got %0d, required 2", pops - p0); end
    n_checks++; if (outstanding_o !== 2'd2) begin n_fail++; $display("FAIL cap_outstanding: got %0d, required 2", outstanding_o); end
    n_checks++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL cap_gate_closed: got %b, required 0", req_valid_o); end
    step();
    n_checks++; if ((pops - p0) != 2) begin n_fail++; $display("FAIL cap_still_held: got %0d pops, required 2", pops - p0); end
    trans_complete_i = 1'b1;
    step();
    trans_complete_i = 1'b0;
    n_checks++; if (req_valid_o !== 1'b1 || outstanding_o !== 2'd1) begin n_fail++; $display("FAIL cap_reopen: got valid=%b out=%0d, required valid=1 out=1", req_valid_o, outstanding_o); end
    step();
    n_checks++; if ((pops - p0) != 3 || outstanding_o !== 2'd2) begin n_fail++; $display("FAIL cap_third_pop: got pops=%0d out=%0d, required pops=3 out=2", pops - p0, outstanding_o); end
    drain("cap", p0, 3);
  endtask

  task automatic test_full_push_pop();
    int p0;
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_i = mk(8'(8'hD0 + i), 24'(200 + i));
      req_valid_i = 1'b1;
      step();
    end
    p0 = pops;
    req_i = mk(8'hD4, 24'd204);
    req_ready_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b, required 0", req_ready_o); end
    step();
    n_checks++; if ((pops - p0) != 1 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_only: got pops=%0d ready=%b, required pops=1 ready=1", pops - p0, req_ready_o); end
    step();
    req_valid_i = 1'b0;
    n_checks++; if ((pops - p0) != 2 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_push_and_pop: got pops=%0d ready=%b, required pops=2 ready=1", pops - p0, req_ready_o); end
    n_checks++; if (exp_q.size() != 3) begin n_fail++; $display("FAIL full_occupancy: got %0d queued, required 3", exp_q.size()); end
    drain("full", p0, 5);
  endtask

  task automatic test_same_cycle();
    int p0;
    p0 = pops;
    req_ready_i = 1'b1;
    req_i = mk(8'hE0, 24'd32);
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    n_checks++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL same_setup: got %0d, required 1", outstanding_o); end
    req_i = mk(8'hE1, 24'd48);
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    trans_complete_i = 1'b1;
    step();
    trans_complete_i = 1'b0;
    n_checks++; if (outstanding_o !== 2'd1 || (pops - p0) != 2) begin n_fail++; $display("FAIL same_pop_retire: got out=%0d pops=%0d, required out=1 pops=2", outstanding_o, pops - p0); end
    trans_complete_i = 1'b1;
    step();
    trans_complete_i = 1'b0;
    n_checks++; if (outstanding_o !== 2'd0 || idle_o !== 1'b1) begin n_fail++; $display("FAIL same_final: got out=%0d idle=%b, required out=0 idle=1", outstanding_o, idle_o); end
  endtask

  task automatic test_snoop();
    int rv[10]  = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    int rr[10]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int rl[10]  = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    int rid[10] = '{1, 1, 1, 2, 1, 0, 1, 1, 1, 0};
    int bv[10]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int br[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int bid[10] = '{0, 0, 0, 0, 1, 1, 2, 1, 1, 0};
    int er[10]  = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
    int ew[10]  = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      axi_rvalid_i = (rv[i] != 0);
      axi_rready_i = (rr[i] != 0);
      axi_rlast_i  = (rl[i] != 0);
      axi_rid_i    = 4'(rid[i]);
      axi_bvalid_i = (bv[i] != 0);
      axi_bready_i = (br[i] != 0);
      axi_bid_i    = 4'(bid[i]);
      step();
      $display("snoop cycle %0d r_done=%b w_done=%b", i, r_done_o, w_done_o);
      n_checks++; if (r_done_o !== (er[i] != 0)) begin n_fail++; $display("FAIL snoop_r_done_%0d: got %b, required %0d", i, r_done_o, er[i]); end
      n_checks++; if (w_done_o !== (ew[i] != 0)) begin n_fail++; $display("FAIL snoop_w_done_%0d: got %b, required %0d", i, w_done_o, ew[i]); end
    end
    step();
    n_checks++; if ({r_done_o, w_done_o} !== 2'b00) begin n_fail++; $display("FAIL snoop_quiet: got %b, required 00", {r_done_o, w_done_o}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_outstanding();
    test_full_push_pop();
    test_same_cycle();
    test_snoop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
